// File: rtl/peach_mem_responder.sv
// rtl/peach_mem_responder.sv - peach32 data-memory responder: wait states, RV32I sizing, fault flags
// Optional LED MMIO register at 0xFFFF_FFF0 enabled by defining PEACH_MEM_MMIO_EN.
module peach_mem_responder #(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [7:0]  led_out
);
    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [2:0]  funct3_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic          acc_now;
    logic          a_we;
    logic [31:0]   a_addr;
    logic [31:0]   a_wdata;
    logic [2:0]    a_f3;
    logic [IW-1:0] widx;
    logic          mmio_hit;
    logic          size_bad;
    logic          align_bad;
    logic          range_bad;
    logic          acc_err;
    logic [3:0]    be;
    logic [31:0]   wlane;
    logic [31:0]   rword;
    logic [31:0]   rshift;
    logic [31:0]   ldata;

`ifdef PEACH_MEM_MMIO_EN
    localparam logic [29:0] MMIO_WORD = 30'h3FFF_FFFC;
    logic [7:0] led_q;
`endif

    assign req_ready = (state_q == ST_IDLE);

    // With zero wait states the access happens straight off the live request fields.
    assign acc_now = ((state_q == ST_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                     ((state_q == ST_WAIT) && (cnt_q == 4'd0));

    always_comb begin
        a_we    = we_q;
        a_addr  = addr_q;
        a_wdata = wdata_q;
        a_f3    = funct3_q;
        if (state_q == ST_IDLE) begin
            a_we    = req_we;
            a_addr  = req_addr;
            a_wdata = req_wdata;
            a_f3    = req_funct3;
        end
        widx     = a_addr[IW+1:2];
        mmio_hit = 1'b0;
`ifdef PEACH_MEM_MMIO_EN
        mmio_hit = (a_addr[31:2] == MMIO_WORD);
`endif
        size_bad  = (a_f3 == 3'b011) || (a_f3[2:1] == 2'b11);
        align_bad = ((a_f3[1:0] == 2'b01) && a_addr[0]) ||
                    ((a_f3 == 3'b010) && (a_addr[1:0] != 2'b00));
        range_bad = !mmio_hit && ({2'b00, a_addr[31:2]} >= 32'(DEPTH_WORDS));
        acc_err   = size_bad || align_bad || range_bad;

        case (a_f3[1:0])
            2'b00: begin
                be    = 4'b0001 << a_addr[1:0];
                wlane = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                be    = a_addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{a_wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = a_wdata;
            end
        endcase

        rword = mem[widx];
`ifdef PEACH_MEM_MMIO_EN
        if (mmio_hit) rword = {24'h0, led_q};
`endif
        rshift = rword >> {a_addr[1:0], 3'b000};
        case (a_f3)
            3'b000:  ldata = {{24{rshift[7]}}, rshift[7:0]};
            3'b001:  ldata = {{16{rshift[15]}}, rshift[15:0]};
            3'b100:  ldata = {24'h0, rshift[7:0]};
            3'b101:  ldata = {16'h0, rshift[15:0]};
            default: ldata = rshift;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            funct3_q  <= 3'b000;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        funct3_q <= req_funct3;
                        if (WAIT_CYCLES != 0) begin
                            state_q <= ST_WAIT;
                            cnt_q   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q   <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            if (acc_now) begin
                state_q   <= ST_RESP;
                rsp_valid <= 1'b1;
                rsp_err   <= acc_err;
                rsp_rdata <= (acc_err || a_we) ? 32'h0 : ldata;
            end
        end
    end

    // Reset is asynchronous, so an in-flight store must also be blocked here.
    always_ff @(posedge clk) begin
        if (acc_now && !reset && a_we && !acc_err && !mmio_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

`ifdef PEACH_MEM_MMIO_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_q <= 8'h00;
        end else if (acc_now && a_we && !acc_err && mmio_hit) begin
            led_q <= wlane[7:0];
        end
    end
    assign led_out = led_q;
`else
    assign led_out = 8'h00;
`endif

endmodule
